// File: rtl/vram_rect_fill.sv
// vram_rect_fill: rectangle-fill engine driving the write port of the
// 64x64 x 8-bit VGA VRAM.
//
// One command is accepted per valid/ready handshake. The engine writes one
// pixel per clk cycle in row-major order and suppresses writes that fall
// outside the VRAM.
//
// Build option: define VRAM_RECT_FILL_VSYNC_WAIT_EN to hold each non-empty
// fill until the next falling edge of the display's active-low vsync, so the
// frame being scanned out is never torn. Without it, vsync is ignored.
module vram_rect_fill #(
  parameter int C_COORD_BITS = 6,
  parameter int C_DATA_BITS  = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [C_COORD_BITS-1:0]        cmd_x,
  input  logic [C_COORD_BITS-1:0]        cmd_y,
  input  logic [C_COORD_BITS:0]          cmd_w,
  input  logic [C_COORD_BITS:0]          cmd_h,
  input  logic [C_DATA_BITS-1:0]         cmd_color,
  output logic                           busy,
  output logic                           done,
  input  logic                           vsync,
  output logic signed [31:0]             data_address,
  output logic signed [C_DATA_BITS-1:0]  data_din,
  output logic                           data_we
);

  // Counters and coordinate sums carry one spare bit so that a sum past the
  // VRAM edge is visible as an overflow instead of wrapping to column/row 0.
  localparam int CB  = C_COORD_BITS;
  localparam int SB  = C_COORD_BITS + 1;
  localparam int PAD = 32 - 2 * C_COORD_BITS;
  localparam logic [SB-1:0] ONE  = {{(SB-1){1'b0}}, 1'b1};
  localparam logic [SB-1:0] ZERO = '0;

`ifdef VRAM_RECT_FILL_VSYNC_WAIT_EN
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FILL    = 2'd1,
    S_DONE    = 2'd2,
    S_WAIT_VS = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;
`endif

  state_t                 state_reg;
  logic [CB-1:0]          x_reg;
  logic [CB-1:0]          y_reg;
  logic [SB-1:0]          w_reg;
  logic [SB-1:0]          h_reg;
  logic [C_DATA_BITS-1:0] color_reg;
  logic [SB-1:0]          i_reg;
  logic [SB-1:0]          j_reg;

  logic [SB-1:0]          i_next;
  logic [SB-1:0]          j_next;
  logic                   last_pix;
  logic                   cmd_empty;
  logic [CB-1:0]          base_x;
  logic [CB-1:0]          base_y;
  logic [SB-1:0]          off_x;
  logic [SB-1:0]          off_y;
  logic [SB-1:0]          pix_x;
  logic [SB-1:0]          pix_y;
  logic                   pix_vis;
  logic [31:0]            pix_addr;
  logic                   vs_fall;

  assign cmd_ready = (state_reg == S_IDLE) && !reset;
  assign cmd_empty = (cmd_w == ZERO) || (cmd_h == ZERO);

`ifdef VRAM_RECT_FILL_VSYNC_WAIT_EN
  // vsync comes from the pixel clock domain. vs_meta_reg/vs_sync_reg form
  // the synchronizer; vs_prev_reg keeps one older sample for edge detection.
  // Reset to 1 (inactive) so leaving reset never fakes a falling edge.
  logic vs_meta_reg;
  logic vs_sync_reg;
  logic vs_prev_reg;

  // Synchronize vsync and keep the previous synchronized sample
  always_ff @(posedge clk) begin
    if (reset) begin
      vs_meta_reg <= 1'b1;
      vs_sync_reg <= 1'b1;
      vs_prev_reg <= 1'b1;
    end else begin
      vs_meta_reg <= vsync;
      vs_sync_reg <= vs_meta_reg;
      vs_prev_reg <= vs_sync_reg;
    end
  end

  assign vs_fall = vs_prev_reg && !vs_sync_reg;
`else
  logic unused_vsync;
  assign unused_vsync = vsync;
  assign vs_fall      = 1'b0;
`endif

  // Next pixel to put on the write port: counter step, end-of-rectangle
  // test, and the clipped address/enable for that pixel
  always_comb begin
    i_next   = i_reg + ONE;
    j_next   = j_reg;
    if (i_reg == w_reg - ONE) begin
      i_next = ZERO;
      j_next = j_reg + ONE;
    end
    last_pix = (i_reg == w_reg - ONE) && (j_reg == h_reg - ONE);

    // On accept the latched registers are not yet loaded, so take the origin
    // straight from the command; in FILL present the pixel after the current.
    base_x = x_reg;
    base_y = y_reg;
    off_x  = ZERO;
    off_y  = ZERO;
    if (state_reg == S_IDLE) begin
      base_x = cmd_x;
      base_y = cmd_y;
    end else if (state_reg == S_FILL) begin
      off_x = i_next;
      off_y = j_next;
    end

    pix_x    = {1'b0, base_x} + off_x;
    pix_y    = {1'b0, base_y} + off_y;
    pix_vis  = !pix_x[CB] && !pix_y[CB];
    pix_addr = {{PAD{1'b0}}, pix_y[CB-1:0], pix_x[CB-1:0]};
  end

  // Control FSM with registered write-port and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      x_reg        <= '0;
      y_reg        <= '0;
      w_reg        <= '0;
      h_reg        <= '0;
      color_reg    <= '0;
      i_reg        <= '0;
      j_reg        <= '0;
      data_we      <= 1'b0;
      data_address <= '0;
      data_din     <= '0;
      done         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      data_we <= 1'b0;
      done    <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (cmd_valid) begin
            x_reg     <= cmd_x;
            y_reg     <= cmd_y;
            w_reg     <= cmd_w;
            h_reg     <= cmd_h;
            color_reg <= cmd_color;
            i_reg     <= ZERO;
            j_reg     <= ZERO;
            busy      <= 1'b1;
            if (cmd_empty) begin
              state_reg <= S_DONE;
              done      <= 1'b1;
            end else begin
`ifdef VRAM_RECT_FILL_VSYNC_WAIT_EN
              state_reg <= S_WAIT_VS;
`else
              // Pixel 0 goes out right away so the RAM takes it next edge
              state_reg    <= S_FILL;
              data_we      <= pix_vis;
              data_address <= pix_addr;
              data_din     <= cmd_color;
`endif
            end
          end
        end
`ifdef VRAM_RECT_FILL_VSYNC_WAIT_EN
        S_WAIT_VS: begin
          if (vs_fall) begin
            state_reg    <= S_FILL;
            data_we      <= pix_vis;
            data_address <= pix_addr;
            data_din     <= color_reg;
          end
        end
`endif
        S_FILL: begin
          if (last_pix) begin
            state_reg <= S_DONE;
            done      <= 1'b1;
          end else begin
            i_reg        <= i_next;
            j_reg        <= j_next;
            data_we      <= pix_vis;
            data_address <= pix_addr;
            data_din     <= color_reg;
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
          busy      <= 1'b0;
        end
        default: begin
          state_reg <= S_IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_rect_fill.sv
// Self-checking bench for vram_rect_fill: directed cases then random
// rectangles, each compared cycle by cycle with a row-major reference.
module tb_vram_rect_fill;

  logic               clk;
  logic               reset;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [5:0]         cmd_x;
  logic [5:0]         cmd_y;
  logic [6:0]         cmd_w;
  logic [6:0]         cmd_h;
  logic [7:0]         cmd_color;
  logic               busy;
  logic               done;
  logic               vsync;
  logic signed [31:0] data_address;
  logic signed [7:0]  data_din;
  logic               data_we;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  vram_rect_fill dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_x        (cmd_x),
    .cmd_y        (cmd_y),
    .cmd_w        (cmd_w),
    .cmd_h        (cmd_h),
    .cmd_color    (cmd_color),
    .busy         (busy),
    .done         (done),
    .vsync        (vsync),
    .data_address (data_address),
    .data_din     (data_din),
    .data_we      (data_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    cmd_x     = 6'($urandom);
    cmd_y     = 6'($urandom);
    cmd_w     = 7'($urandom);
    cmd_h     = 7'($urandom);
    cmd_color = 8'($urandom);
  endtask

  // Issue one command and check every cycle against the rectangle model.
  // abort_at >= 0 pulses reset right after pixel abort_at has been checked.
  task automatic run_cmd(input int x, input int y, input int w, input int h,
                         input int color, input int abort_at);
    int n;
    int row;
    int col;
    int ex;
    int ey;
    n = w * h;
    cmd_x = 6'(x); cmd_y = 6'(y); cmd_w = 7'(w); cmd_h = 7'(h);
    cmd_color = 8'(color);
    cmd_valid = 1'b1;
    chk("ready_before", {31'b0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    scramble();
    if (n == 0) begin
      chk("empty_done", {31'b0, done}, 32'd1);
      chk("empty_we", {31'b0, data_we}, 32'd0);
      chk("empty_busy", {31'b0, busy}, 32'd1);
    end else begin
`ifdef VRAM_RECT_FILL_VSYNC_WAIT_EN
      for (int c = 0; c < 3; c++) begin
        chk("wait_we", {31'b0, data_we}, 32'd0);
        chk("wait_busy", {31'b0, busy}, 32'd1);
        tick();
      end
      vsync = 1'b0;
      tick();
      chk("sync_we", {31'b0, data_we}, 32'd0);
      tick();
      chk("sync_we", {31'b0, data_we}, 32'd0);
      tick();
`endif
      for (int k = 0; k < n; k++) begin
        row = k / w;
        col = k % w;
        ex  = x + col;
        ey  = y + row;
        chk("pix_we", {31'b0, data_we}, ((ex < 64) && (ey < 64)) ? 32'd1 : 32'd0);
        chk("pix_addr", data_address, 32'((ey % 64) * 64 + (ex % 64)));
        chk("pix_din", 32'($unsigned(data_din)), 32'(color));
        chk("pix_busy", {31'b0, busy}, 32'd1);
        chk("pix_done", {31'b0, done}, 32'd0);
        chk("pix_ready", {31'b0, cmd_ready}, 32'd0);
`ifdef VRAM_RECT_FILL_VSYNC_WAIT_EN
        vsync = 1'($urandom);
`endif
        if (k == abort_at) begin
          cmd_valid = 1'b0;
          reset = 1'b1;
          tick();
          chk("abort_we", {31'b0, data_we}, 32'd0);
          chk("abort_busy", {31'b0, busy}, 32'd0);
          chk("abort_done", {31'b0, done}, 32'd0);
          chk("abort_ready_in_reset", {31'b0, cmd_ready}, 32'd0);
          reset = 1'b0;
          vsync = 1'b1;
          tick();
          chk("abort_done_after", {31'b0, done}, 32'd0);
          chk("abort_ready_after", {31'b0, cmd_ready}, 32'd1);
          tick();
          return;
        end
        cmd_valid = 1'($urandom);
        tick();
      end
      cmd_valid = 1'b0;
`ifdef VRAM_RECT_FILL_VSYNC_WAIT_EN
      vsync = 1'b1;
`endif
      chk("done_pulse", {31'b0, done}, 32'd1);
      chk("done_we", {31'b0, data_we}, 32'd0);
      chk("done_busy", {31'b0, busy}, 32'd1);
    end
    cmd_valid = 1'b0;
    tick();
    chk("after_done", {31'b0, done}, 32'd0);
    chk("after_busy", {31'b0, busy}, 32'd0);
    chk("after_ready", {31'b0, cmd_ready}, 32'd1);
  endtask

  initial begin
    int wait_cnt;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    vsync     = 1'b1;
    scramble();

    // Reset state, during and one cycle after reset
    tick();
    chk("rst_we", {31'b0, data_we}, 32'd0);
    chk("rst_addr", data_address, 32'd0);
    chk("rst_din", 32'($unsigned(data_din)), 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ready", {31'b0, cmd_ready}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_we", {31'b0, data_we}, 32'd0);
    chk("post_rst_addr", data_address, 32'd0);
    chk("post_rst_done", {31'b0, done}, 32'd0);
    chk("post_rst_ready", {31'b0, cmd_ready}, 32'd1);

    // Directed cases
    run_cmd(3, 5, 1, 1, 8'hE0, -1);
    run_cmd(10, 20, 2, 2, 8'h1C, -1);
    run_cmd(62, 63, 4, 2, 8'hFF, -1);
    run_cmd(0, 0, 0, 5, 8'h55, -1);
    run_cmd(7, 0, 5, 0, 8'h12, -1);
    run_cmd(0, 0, 8, 8, 8'hA5, 9);
    run_cmd(1, 2, 1, 1, 8'h3C, -1);
    run_cmd(0, 0, 64, 64, 8'h81, -1);
    run_cmd(9, 61, 64, 3, 8'h6E, -1);

`ifdef VRAM_RECT_FILL_VSYNC_WAIT_EN
    // Fill held off while vsync stays high, then released by its fall
    cmd_x = 6'd4; cmd_y = 6'd6; cmd_w = 7'd2; cmd_h = 7'd1; cmd_color = 8'h47;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int c = 0; c < 100; c++) begin
      chk("vs_hold_we", {31'b0, data_we}, 32'd0);
      chk("vs_hold_busy", {31'b0, busy}, 32'd1);
      tick();
    end
    vsync = 1'b0;
    wait_cnt = 0;
    while (!data_we && wait_cnt < 4) begin
      tick();
      wait_cnt++;
    end
    chk("vs_first_write_seen", {31'b0, data_we}, 32'd1);
    chk("vs_pix0_addr", data_address, 32'(6 * 64 + 4));
    vsync = 1'b1;
    tick();
    chk("vs_pix1_we", {31'b0, data_we}, 32'd1);
    chk("vs_pix1_addr", data_address, 32'(6 * 64 + 5));
    vsync = 1'b0;
    tick();
    chk("vs_done", {31'b0, done}, 32'd1);
    vsync = 1'b1;
    tick();
    tick();
    tick();
`else
    wait_cnt = 0;
`endif

    // Random rectangles, clipping included
    for (int t = 0; t < 40; t++) begin
      run_cmd(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
              int'($urandom_range(0, 10)), int'($urandom_range(0, 10)),
              int'($urandom_range(0, 255)), -1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
